image_median_a: RTL and testbench
=================================

# image_median_a

Consumer end of the 3x3 window interface. Takes the nine window taps and tap-valid strobe from the line-buffer window generator and applies a pipelined 3x3 median (or centre-tap bypass). Returns a single 8-bit pixel stream with row and frame markers for the downstream eye-tracking stages. Output geometry is the valid-window region: (H_ACTIVE-2) x (V_ACTIVE-2) pixels per frame.

## Interface

Parameters:
- H_ACTIVE, 1280: input image width; output row length is H_ACTIVE-2.
- V_ACTIVE, 720: input image height; output rows per frame is V_ACTIVE-2.

Ports:
- i_clk  in  1  single clock, all logic rising-edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_en  in  1  window valid; taps are meaningful only when high.
- i_temp_11 .. i_temp_33  in  8 each  window taps, row-major. Row 1 is the oldest line, column 3 the newest pixel. i_temp_22 is the centre.
- i_mode  in  1  0 = median, 1 = bypass (centre tap); sampled with i_en.
- o_en  out  1  output pixel valid.
- o_data  out  8  filtered pixel.
- o_eol  out  1  high with o_en on the last pixel of an output row.
- o_eof  out  1  high with o_en on the last pixel of an output frame (o_eol also high).

## Operation

- **Pipeline.** Free-running three-stage pipeline with a valid bit per stage, advancing every cycle. Gaps in i_en propagate as bubbles; there is no back-pressure.
- **Stage 1.** Per window row r, produce min_r, mid_r and max_r of (i_temp_r1, i_temp_r2, i_temp_r3). Also register i_temp_22 and i_mode.
- **Stage 2.** Compute:
  - A = max(min_1, min_2, min_3)
  - B = mid(mid_1, mid_2, mid_3)
  - C = min(max_1, max_2, max_3)
- **Stage 3.** o_data = mid(A, B, C) when mode = 0; otherwise the delayed centre tap.
- **Comparisons.** Unsigned 8-bit. Ties resolve to either operand; the value is identical, so the result is deterministic.
- **Output counters.** out_h counts 0..H_ACTIVE-3 and out_v counts 0..V_ACTIVE-3. Both advance only on o_en.
  - out_h wraps to 0 after H_ACTIVE-3; out_v increments on that wrap.
  - out_v wraps to 0 after V_ACTIVE-3 on the eof pixel.
- **Markers.** o_eol = o_en && out_h == H_ACTIVE-3. o_eof = o_eol && out_v == V_ACTIVE-3. Both are combinational from registered counters plus the registered o_en.
- **Reset.** All outputs are 0 on reset: o_en, o_data, o_eol and o_eof. All pipeline valid bits, data registers and counters also clear.
- **Reset mid-frame.** Pipeline contents are discarded, with no partial pixels emitted after release. The counters restart at (0,0). Re-alignment depends on the upstream generator being reset in the same event.
- **Mode change.** i_mode is captured per pixel, so a change takes effect on the pixel it accompanies. There is no frame-boundary gating.

## Timing

- **Latency.** Exactly 3 cycles from i_en high (taps sampled) to the corresponding o_en high.
- **Throughput.** One pixel per cycle sustained; back-to-back i_en is fully supported.
- **Data alignment.** o_data, o_eol and o_eof are valid only in cycles with o_en high. In other cycles o_data holds its last value and o_eol/o_eof are 0.
- **Critical path.** At most one 3-input sort per stage, i.e. three comparators plus a mux.

## Structure

- **Shared package image_pkg_a:**
  - PIX_W = 8.
  - Functions min3, max3 and mid3 on PIX_W-bit operands.
  - Default geometry constants for H_ACTIVE and V_ACTIVE.
- **Sub-module image_sort3_a.** Registered 3-input sorter with inputs a, b, c and outputs min, mid and max, clocked and reset like the parent.
  - Stage 1 instantiates three of them, one per window row.
  - Stages 2 and 3 use the package functions directly.
- **Top level.** Holds the valid pipeline, mode/centre delay line, output counters and markers.

## Test plan

Run with H_ACTIVE = 6, V_ACTIVE = 5 unless stated.

- **Constant window:** all taps 8'h40, mode 0, one i_en pulse -> o_en exactly 3 cycles later with o_data = 8'h40.
- **Permuted ranks:** taps 9,1,7 / 3,5,2 / 8,4,6, mode 0 -> o_data = 5. Repeat with the same values in 20 random permutations -> always 5.
- **Salt noise and bypass:**
  - Centre 255, others 10, mode 0 -> 10.
  - Same taps, mode 1 -> 255.
  - Alternate mode every pixel on back-to-back input -> outputs alternate 10/255 in order.
- **Geometry and markers:** 12 i_en pulses with random gaps ->
  - 12 o_en pulses.
  - o_eol on pulses 4, 8 and 12.
  - o_eof only on pulse 12.
  - A 13th pulse -> counters restart, o_eol next on pulse 16.
- **Back-to-back throughput:** 100 consecutive i_en cycles -> 100 consecutive o_en cycles starting 3 cycles later, each matching a reference median model.
- **Reset:**
  - Assert i_rst_n low with two pixels in the pipeline -> o_en, o_data, o_eol and o_eof go 0 asynchronously, and no o_en follows release.
  - After release, 4 pixels -> o_eol on the 4th.

Source files
------------

// File: rtl/image_pkg_a.sv
// image_pkg_a: pixel width, default geometry and 3-input min/mid/max helpers for the median filter.
package image_pkg_a;
  localparam int PIX_W = 8;
  localparam int H_ACTIVE_DEF = 1280;
  localparam int V_ACTIVE_DEF = 720;

  function automatic logic [PIX_W-1:0] min3(input logic [PIX_W-1:0] a, b, c);
    logic [PIX_W-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic [PIX_W-1:0] max3(input logic [PIX_W-1:0] a, b, c);
    logic [PIX_W-1:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Median is the larger of min(a,b) and min(max(a,b),c).
  function automatic logic [PIX_W-1:0] mid3(input logic [PIX_W-1:0] a, b, c);
    logic [PIX_W-1:0] lo, hi, t;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    t = (hi < c) ? hi : c;
    return (lo > t) ? lo : t;
  endfunction
endpackage

// File: rtl/image_sort3_a.sv
// image_sort3_a: registered 3-input sorter producing min, mid and max of one window row.
module image_sort3_a
  import image_pkg_a::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [PIX_W-1:0] a,
  input  logic [PIX_W-1:0] b,
  input  logic [PIX_W-1:0] c,
  output logic [PIX_W-1:0] min,
  output logic [PIX_W-1:0] mid,
  output logic [PIX_W-1:0] max
);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      min <= '0;
      mid <= '0;
      max <= '0;
    end else begin
      min <= min3(a, b, c);
      mid <= mid3(a, b, c);
      max <= max3(a, b, c);
    end
  end
endmodule

// File: rtl/image_median_a.sv
// image_median_a: three-stage pipelined 3x3 median (or centre bypass) with row/frame markers
// over the (H_ACTIVE-2) x (V_ACTIVE-2) valid-window region.
module image_median_a
  import image_pkg_a::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [PIX_W-1:0] i_temp_11,
  input  logic [PIX_W-1:0] i_temp_12,
  input  logic [PIX_W-1:0] i_temp_13,
  input  logic [PIX_W-1:0] i_temp_21,
  input  logic [PIX_W-1:0] i_temp_22,
  input  logic [PIX_W-1:0] i_temp_23,
  input  logic [PIX_W-1:0] i_temp_31,
  input  logic [PIX_W-1:0] i_temp_32,
  input  logic [PIX_W-1:0] i_temp_33,
  input  logic             i_mode,
  output logic             o_en,
  output logic [PIX_W-1:0] o_data,
  output logic             o_eol,
  output logic             o_eof
);
  localparam int HW = $clog2(H_ACTIVE);
  localparam int VW = $clog2(V_ACTIVE);
  localparam logic [HW-1:0] H_LAST = HW'(H_ACTIVE - 3);
  localparam logic [VW-1:0] V_LAST = VW'(V_ACTIVE - 3);

  logic [PIX_W-1:0] col_1 [3];
  logic [PIX_W-1:0] col_2 [3];
  logic [PIX_W-1:0] col_3 [3];
  logic [PIX_W-1:0] mn [3];
  logic [PIX_W-1:0] md [3];
  logic [PIX_W-1:0] mx [3];
  logic             v1, v2, mode1, mode2;
  logic [PIX_W-1:0] ctr1, ctr2, a2, b2, c2;
  logic [HW-1:0]    out_h;
  logic [VW-1:0]    out_v;

  assign col_1 = '{i_temp_11, i_temp_21, i_temp_31};
  assign col_2 = '{i_temp_12, i_temp_22, i_temp_32};
  assign col_3 = '{i_temp_13, i_temp_23, i_temp_33};

  for (genvar r = 0; r < 3; r++) begin : g_row
    image_sort3_a u_sort (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .a      (col_1[r]),
      .b      (col_2[r]),
      .c      (col_3[r]),
      .min    (mn[r]),
      .mid    (md[r]),
      .max    (mx[r])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v1 <= 1'b0;
      mode1 <= 1'b0;
      ctr1 <= '0;
      v2 <= 1'b0;
      mode2 <= 1'b0;
      ctr2 <= '0;
      a2 <= '0;
      b2 <= '0;
      c2 <= '0;
      o_en <= 1'b0;
      o_data <= '0;
    end else begin
      v1 <= i_en;
      mode1 <= i_mode;
      ctr1 <= i_temp_22;
      v2 <= v1;
      mode2 <= mode1;
      ctr2 <= ctr1;
      a2 <= max3(mn[0], mn[1], mn[2]);
      b2 <= mid3(md[0], md[1], md[2]);
      c2 <= min3(mx[0], mx[1], mx[2]);
      o_en <= v2;
      if (v2) o_data <= mode2 ? ctr2 : mid3(a2, b2, c2);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_h <= '0;
      out_v <= '0;
    end else if (o_en) begin
      out_h <= (out_h == H_LAST) ? '0 : out_h + HW'(1);
      if (out_h == H_LAST) out_v <= (out_v == V_LAST) ? '0 : out_v + VW'(1);
    end
  end

  assign o_eol = o_en && out_h == H_LAST;
  assign o_eof = o_eol && out_v == V_LAST;
endmodule

// File: tb/tb_image_median_a.sv
// tb_image_median_a: randomized bench comparing the median filter against a sort-based reference
// with a pixel-indexed marker model and a per-pixel latency scoreboard.
module tb_image_median_a;
  localparam int H = 6;
  localparam int V = 5;
  localparam int ROW = H - 2;
  localparam int FRM = (H - 2) * (V - 2);

  typedef struct {
    int         due;
    logic [7:0] data;
  } exp_t;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_en = 1'b0;
  logic       i_mode = 1'b0;
  logic [7:0] i_temp_11 = '0, i_temp_12 = '0, i_temp_13 = '0;
  logic [7:0] i_temp_21 = '0, i_temp_22 = '0, i_temp_23 = '0;
  logic [7:0] i_temp_31 = '0, i_temp_32 = '0, i_temp_33 = '0;
  logic       o_en, o_eol, o_eof;
  logic [7:0] o_data;

  logic [7:0] taps [9];
  exp_t       q [$];
  int         cyc = 0;
  int         k = 0;
  int         n_vec = 0;
  int         n_err = 0;

  image_median_a #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_en     (i_en),
    .i_temp_11(i_temp_11),
    .i_temp_12(i_temp_12),
    .i_temp_13(i_temp_13),
    .i_temp_21(i_temp_21),
    .i_temp_22(i_temp_22),
    .i_temp_23(i_temp_23),
    .i_temp_31(i_temp_31),
    .i_temp_32(i_temp_32),
    .i_temp_33(i_temp_33),
    .i_mode   (i_mode),
    .o_en     (o_en),
    .o_data   (o_data),
    .o_eol    (o_eol),
    .o_eof    (o_eof)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] med9(input logic [7:0] v [9]);
    logic [7:0] s [9];
    logic [7:0] t;
    s = v;
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (s[j] > s[j+1]) begin
          t = s[j];
          s[j] = s[j+1];
          s[j+1] = t;
        end
    return s[4];
  endfunction

  task automatic observe();
    exp_t e;
    if (o_en) begin
      if (q.size() == 0) check("spurious_en", {31'b0, o_en}, 32'd0);
      else begin
        e = q.pop_front();
        check("latency", cyc, e.due);
        check("data", {24'b0, o_data}, {24'b0, e.data});
        check("eol", {31'b0, o_eol}, {31'b0, (k % ROW) == ROW - 1});
        check("eof", {31'b0, o_eof}, {31'b0, (k % FRM) == FRM - 1});
        k++;
      end
    end else begin
      check("eol_idle", {31'b0, o_eol}, 32'd0);
      check("eof_idle", {31'b0, o_eof}, 32'd0);
      if (q.size() != 0 && q[0].due <= cyc) begin
        check("missing_en", {31'b0, o_en}, 32'd1);
        void'(q.pop_front());
      end
    end
  endtask

  task automatic cycle(input logic en, input logic mode);
    exp_t e;
    @(negedge i_clk);
    observe();
    i_en = en;
    i_mode = mode;
    {i_temp_11, i_temp_12, i_temp_13} = {taps[0], taps[1], taps[2]};
    {i_temp_21, i_temp_22, i_temp_23} = {taps[3], taps[4], taps[5]};
    {i_temp_31, i_temp_32, i_temp_33} = {taps[6], taps[7], taps[8]};
    if (en) begin
      e.due = cyc + 3;
      e.data = mode ? taps[4] : med9(taps);
      q.push_back(e);
    end
  endtask

  task automatic rand_taps();
    for (int i = 0; i < 9; i++) taps[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic shuffle();
    logic [7:0] t;
    int j;
    for (int i = 8; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = taps[i];
      taps[i] = taps[j];
      taps[j] = t;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
  endtask

  initial begin
    taps = '{default: 8'h00};
    #12;
    check("rst_en", {31'b0, o_en}, 32'd0);
    check("rst_data", {24'b0, o_data}, 32'd0);
    check("rst_eol", {31'b0, o_eol}, 32'd0);
    check("rst_eof", {31'b0, o_eof}, 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    idle(2);

    taps = '{default: 8'h40};
    cycle(1'b1, 1'b0);
    idle(5);

    taps = '{8'd9, 8'd1, 8'd7, 8'd3, 8'd5, 8'd2, 8'd8, 8'd4, 8'd6};
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      shuffle();
      cycle(1'b1, 1'b0);
      idle($urandom_range(0, 1));
    end
    idle(4);

    taps = '{8'd10, 8'd10, 8'd10, 8'd10, 8'd255, 8'd10, 8'd10, 8'd10, 8'd10};
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b1, i[0]);
    idle(4);

    for (int i = 0; i < 16; i++) begin
      rand_taps();
      cycle(1'b1, 1'b0);
      idle($urandom_range(0, 3));
    end
    idle(4);

    for (int i = 0; i < 100; i++) begin
      rand_taps();
      cycle(1'b1, 1'b0);
    end
    idle(4);

    for (int i = 0; i < 150; i++) begin
      rand_taps();
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    idle(4);

    rand_taps();
    cycle(1'b1, 1'b0);
    rand_taps();
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    #2 i_rst_n = 1'b0;
    #1;
    check("midrst_en", {31'b0, o_en}, 32'd0);
    check("midrst_data", {24'b0, o_data}, 32'd0);
    check("midrst_eol", {31'b0, o_eol}, 32'd0);
    check("midrst_eof", {31'b0, o_eof}, 32'd0);
    q.delete();
    k = 0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    idle(6);
    for (int i = 0; i < 4; i++) begin
      rand_taps();
      cycle(1'b1, 1'b0);
    end
    idle(5);
    check("drained", q.size(), 32'd0);
    check("post_rst_count", k, 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
